// File: rtl/ir_queue_if.sv
// rtl/ir_queue_if.sv - fetch/decode handshake bundle for the instruction queue
interface ir_queue_if #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                IRWre;
  logic [31:0]         IDataOut;
  logic [PC_WIDTH-1:0] PCIn;
  logic                ready;
  logic                pop;
  logic                flush;
  logic                ExtSel;
  logic                valid;
  logic                full;
  logic [CW-1:0]       count;
  logic [5:0]          op;
  logic [4:0]          rs;
  logic [4:0]          rt;
  logic [4:0]          rd;
  logic [4:0]          sa;
  logic [5:0]          funct;
  logic [15:0]         immediate;
  logic [31:0]         ext_imm;
  logic [25:0]         jaddr;
  logic [PC_WIDTH-1:0] PCOut;

  modport master (
    output IRWre, IDataOut, PCIn, pop, flush, ExtSel,
    input  ready, valid, full, count, op, rs, rt, rd, sa, funct,
           immediate, ext_imm, jaddr, PCOut
  );

  modport slave (
    input  IRWre, IDataOut, PCIn, pop, flush, ExtSel,
    output ready, valid, full, count, op, rs, rt, rd, sa, funct,
           immediate, ext_imm, jaddr, PCOut
  );
endinterface

// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - DEPTH-entry instruction FIFO with PC tags and pre-decoded head fields
module ir_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input logic     CLK,
  input logic     RST,
  ir_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]         word_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem   [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic                valid;
  logic                full;
  logic                do_push;
  logic                do_pop;
  logic [31:0]         head_word;
  logic [PC_WIDTH-1:0] head_pc;

  assign valid   = (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  // A pop frees the head slot this cycle, so a full queue can still take a word.
  assign q.ready = !full || q.pop;
  assign do_push = q.IRWre && q.ready && !q.flush;
  assign do_pop  = q.pop && valid && !q.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) begin
      word_mem[wr_ptr_q] <= q.IDataOut;
      pc_mem[wr_ptr_q]   <= q.PCIn;
    end
  end

  // Storage is never cleared, so gate the head with valid to keep stale words off the outputs.
  assign head_word = valid ? word_mem[rd_ptr_q] : '0;
  assign head_pc   = valid ? pc_mem[rd_ptr_q]   : '0;

  assign q.valid     = valid;
  assign q.full      = full;
  assign q.count     = count_q;
  assign q.op        = head_word[31:26];
  assign q.rs        = head_word[25:21];
  assign q.rt        = head_word[20:16];
  assign q.rd        = head_word[15:11];
  assign q.sa        = head_word[10:6];
  assign q.funct     = head_word[5:0];
  assign q.immediate = head_word[15:0];
  assign q.jaddr     = head_word[25:0];
  assign q.PCOut     = head_pc;
  assign q.ext_imm   = q.ExtSel ? {{16{head_word[15]}}, head_word[15:0]}
                                : {16'b0, head_word[15:0]};
endmodule

// File: tb/tb_ir_queue.sv
// tb/tb_ir_queue.sv - scoreboard bench for ir_queue
module tb_ir_queue;
  localparam int DEPTH    = 4;
  localparam int PC_WIDTH = 32;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] sb[$];

  ir_queue_if #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH)) ifc ();

  ir_queue #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH)) dut (
    .CLK (clk),
    .RST (rst_n),
    .q   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_head();
    logic [63:0] e;
    logic [31:0] w;
    logic [15:0] im;
    e  = (sb.size() != 0) ? sb[0] : 64'd0;
    w  = e[31:0];
    im = w[15:0];
    check("op",        ifc.op,        w[31:26]);
    check("rs",        ifc.rs,        w[25:21]);
    check("rt",        ifc.rt,        w[20:16]);
    check("rd",        ifc.rd,        w[15:11]);
    check("sa",        ifc.sa,        w[10:6]);
    check("funct",     ifc.funct,     w[5:0]);
    check("immediate", ifc.immediate, im);
    check("jaddr",     ifc.jaddr,     w[25:0]);
    check("PCOut",     ifc.PCOut,     e[63:32]);
    check("ext_imm",   ifc.ext_imm,
          ifc.ExtSel ? {{16{im[15]}}, im} : {16'h0, im});
  endtask

  task automatic check_state();
    check("count", ifc.count, sb.size());
    check("valid", ifc.valid, sb.size() != 0);
    check("full",  ifc.full,  sb.size() == DEPTH);
    check_head();
  endtask

  task automatic step(input logic psh, input logic [31:0] w, input logic [31:0] pc,
                      input logic pp, input logic fl);
    bit acc_push, acc_pop;
    ifc.IRWre    = psh;
    ifc.IDataOut = w;
    ifc.PCIn     = pc;
    ifc.pop      = pp;
    ifc.flush    = fl;
    #1;
    check("ready", ifc.ready, (sb.size() != DEPTH) || pp);
    acc_pop  = pp && (sb.size() != 0) && !fl;
    acc_push = psh && ((sb.size() != DEPTH) || pp) && !fl;
    if (acc_pop)
      check("pop_entry", {ifc.PCOut, ifc.op, ifc.rs, ifc.rt, ifc.rd, ifc.sa, ifc.funct}, sb[0]);
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    else begin
      if (acc_pop)  void'(sb.pop_front());
      if (acc_push) sb.push_back({pc, w});
    end
    ifc.IRWre = 1'b0;
    ifc.pop   = 1'b0;
    ifc.flush = 1'b0;
    #1;
    check_state();
  endtask

  initial begin
    rst_n        = 1'b0;
    ifc.IRWre    = 1'b0;
    ifc.IDataOut = '0;
    ifc.PCIn     = '0;
    ifc.pop      = 1'b0;
    ifc.flush    = 1'b0;
    ifc.ExtSel   = 1'b1;
    #1;
    check("rst_ready", ifc.ready, 1'b1);
    check_state();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // lw $2,4($1)
    step(1'b1, 32'h8C220004, 32'h10, 1'b0, 1'b0);
    check("lw_op", ifc.op, 6'h23);
    check("lw_rs", ifc.rs, 5'd1);
    check("lw_rt", ifc.rt, 5'd2);
    check("lw_imm", ifc.immediate, 16'h0004);
    check("lw_pc", ifc.PCOut, 32'h10);

    // pop the lw while pushing addi with a negative immediate
    step(1'b1, 32'h2001FFFF, 32'h14, 1'b1, 1'b0);
    check("ext_sign", ifc.ext_imm, 32'hFFFFFFFF);
    ifc.ExtSel = 1'b0;
    #1;
    check("ext_zero", ifc.ext_imm, 32'h0000FFFF);
    ifc.ExtSel = 1'b1;
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // empty queue: pop ignored, push accepted
    step(1'b1, 32'h00851020, 32'h18, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // fill, drop on full, push+pop on full
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 32'h11110000 + i, 32'h100 + 4 * i, 1'b0, 1'b0);
    check("full_count", ifc.count, DEPTH);
    step(1'b1, 32'hDEADBEEF, 32'h200, 1'b0, 1'b0);
    check("drop_count", ifc.count, DEPTH);
    step(1'b1, 32'h22220000, 32'h204, 1'b1, 1'b0);
    check("fp_count", ifc.count, DEPTH);
    check("fp_head_pc", ifc.PCOut, 32'h104);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // pointer wrap
    for (int i = 0; i < 3; i++) step(1'b1, 32'h33330000 + i, 32'h300 + 4 * i, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 32'h44440000 + i, 32'h400 + 4 * i, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("wrap_empty", ifc.count, 0);

    // flush with push and pop in the same cycle
    for (int i = 0; i < 3; i++) step(1'b1, 32'h55550000 + i, 32'h500 + 4 * i, 1'b0, 1'b0);
    step(1'b1, 32'h66666666, 32'h600, 1'b1, 1'b1);
    check("flush_valid", ifc.valid, 1'b0);
    check("flush_ready", ifc.ready, 1'b1);
    step(1'b1, 32'h77770001, 32'h700, 1'b0, 1'b0);
    check("post_flush_pc", ifc.PCOut, 32'h700);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // asynchronous reset mid-stream
    step(1'b1, 32'h88880000, 32'h800, 1'b0, 1'b0);
    step(1'b1, 32'h88880001, 32'h804, 1'b0, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_state();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 32'h99990000, 32'h900, 1'b0, 1'b0);
    check("post_rst_count", ifc.count, 1);

    // random traffic against the scoreboard
    for (int i = 0; i < 60; i++) begin
      ifc.ExtSel = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register for the multi-cycle CPU. It replaces the single-entry instruction register with a DEPTH-entry FIFO of fetched instruction words and their PCs. The FIFO accepts words from instruction memory under a push handshake and presents the head entry to the control unit and register file as pre-decoded fields. It adds flush for taken branches and jumps, full/empty status, and sign- or zero-extension of the immediate.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- PC_WIDTH, 32, width of the PC tag stored with each word

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- IRWre  in  1  push request; word accepted when IRWre && ready
- IDataOut  in  32  instruction word from instruction memory
- PCIn  in  PC_WIDTH  address of IDataOut
- ready  out  1  queue can accept a push this cycle: !full || pop
- pop  in  1  consume head entry; ignored when !valid
- flush  in  1  discard all entries
- ExtSel  in  1  1 = sign-extend immediate, 0 = zero-extend
- valid  out  1  head entry present (count != 0)
- full  out  1  count == DEPTH
- count  out  $clog2(DEPTH)+1  number of stored entries
- op  out  6  head word [31:26]
- rs  out  5  head word [25:21]
- rt  out  5  head word [20:16]
- rd  out  5  head word [15:11]
- sa  out  5  head word [10:6]
- funct  out  6  head word [5:0]
- immediate  out  16  head word [15:0]
- ext_imm  out  32  immediate extended per ExtSel
- jaddr  out  26  head word [25:0]
- PCOut  out  PC_WIDTH  PC tag of head entry

## Operation
- Storage: DEPTH × (32 + PC_WIDTH) array. Write pointer wr_ptr, read pointer rd_ptr, each $clog2(DEPTH) bits, and count.
- Pointers wrap modulo DEPTH naturally, with no extra logic, because DEPTH is a power of two.
- Push: when IRWre && ready && !flush, write {PCIn, IDataOut} at wr_ptr, then wr_ptr+1.
- Pop: when pop && valid && !flush, rd_ptr+1.
- count update:
  - +1 on push only
  - −1 on pop only
  - unchanged on simultaneous push and pop
- Full with pop: push and pop in the same cycle are both accepted. This is why ready = !full || pop.
- Empty with push: a pop is ignored, and the push is accepted normally.
- IRWre && !ready: word dropped, no state change. The fetch unit must hold the word and retry.
- flush has priority over everything:
  - wr_ptr, rd_ptr and count go to 0 on that edge
  - a push or pop in the same cycle is discarded
  - storage contents need not be cleared
- Decode outputs are combinational from the entry at rd_ptr, gated by valid. When !valid, op, rs, rt, rd, sa, funct, immediate, jaddr, ext_imm and PCOut are all 0.
- ext_imm:
  - ExtSel=1: {{16{immediate[15]}}, immediate}
  - ExtSel=0: {16'b0, immediate}
  - ExtSel is combinational and is not stored per entry.
- Reset values (RST low, immediate, asynchronous):
  - wr_ptr = rd_ptr = count = 0
  - valid = 0, full = 0, ready = 1 (when pop is low)
  - all decode outputs 0
  - storage is not required to be reset

## Timing
- Push-to-visible latency is 1 cycle. A word pushed at edge N appears on the decode outputs after edge N when the queue was empty.
- Pop-to-next-head is 1 cycle. After the pop edge, the outputs show the next entry, or all-zero if the queue is now empty.
- ready, valid, full and count change only on CLK edges or on RST assertion; ready also follows pop combinationally.
- RST asserted mid-operation aborts everything. A push on the first edge after RST deasserts is accepted.
- Flush takes effect at the edge where flush is high. On the following cycle valid = 0 and ready = 1.

## Test plan
- Reset, then push 0x8C220004 (lw $2,4($1)) with PCIn=0x00000010 → next cycle: valid=1, count=1, op=0x23, rs=1, rt=2, immediate=0x0004, PCOut=0x10.
- With ExtSel=1, push 0x2001FFFF → ext_imm=0xFFFFFFFF; set ExtSel=0 with no other change → ext_imm=0x0000FFFF, combinationally.
- Push DEPTH words with no pop → full=1 and count=DEPTH. A further push with pop=0 is dropped and count stays DEPTH. Pushing with pop=1 keeps count=DEPTH and head advances by one.
- Push 3, pop 3, then push 2 more so the pointers wrap (DEPTH=4) → words emerge in push order with correct PCOut, and count goes 0 after the final pop.
- With 3 entries stored, assert flush together with IRWre and pop → next cycle count=0, valid=0, all decode outputs 0; the flushed-cycle push is not stored.
- Pull RST low mid-stream with 2 entries → immediately count=0, valid=0, outputs 0. After release, a push appears 1 cycle later.
